// File: rtl/k6502_regfile.sv
// Programmer-visible register bank (A/X/Y/S by default): bus loads, INC/DEC, transfers,
// dual combinational bus reads and registered Z/N, wrap and reject pulses.
module k6502_regfile #(
    parameter int              WIDTH    = 8,
    parameter int              NREGS    = 4,
    parameter int              SP_IDX   = 3,
    parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(8'hFD),
    parameter int              SELW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             ph0,
    input  logic             reset_n,
    input  logic             rdy,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd_op,
    input  logic [SELW-1:0]  cmd_dst,
    input  logic [SELW-1:0]  cmd_src,
    input  logic [WIDTH-1:0] sb_in,
    input  logic [WIDTH-1:0] db_in,
    input  logic             sb_ren,
    input  logic             db_ren,
    input  logic [SELW-1:0]  sb_rsel,
    input  logic [SELW-1:0]  db_rsel,
    output logic [WIDTH-1:0] sb_out,
    output logic [WIDTH-1:0] db_out,
    output logic             flag_upd,
    output logic             flag_z,
    output logic             flag_n,
    output logic             wrap,
    output logic             cmd_err
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LDSB = 3'd1;
    localparam logic [2:0] OP_LDDB = 3'd2;
    localparam logic [2:0] OP_INC  = 3'd3;
    localparam logic [2:0] OP_DEC  = 3'd4;
    localparam logic [2:0] OP_XFER = 3'd5;
    localparam logic [2:0] OP_CLR  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    logic [NREGS-1:0][WIDTH-1:0] regs;
    logic [WIDTH-1:0] dst_val, src_val, result;
    logic dst_ok, src_ok, is_sp, reject, exec, wr_en, wrap_c;

    // Selects wider than the bank fall through every compare and read as 0.
    always_comb begin
        sb_out  = '0;
        db_out  = '0;
        dst_val = '0;
        src_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (sb_ren && sb_rsel == SELW'(i)) sb_out = regs[i];
            if (db_ren && db_rsel == SELW'(i)) db_out = regs[i];
            if (cmd_dst == SELW'(i)) dst_val = regs[i];
            if (cmd_src == SELW'(i)) src_val = regs[i];
        end
    end

    assign dst_ok = int'(cmd_dst) < NREGS;
    assign src_ok = int'(cmd_src) < NREGS;
    assign is_sp  = int'(cmd_dst) == SP_IDX;
    assign reject = (cmd_op == OP_RSVD) || !dst_ok || (cmd_op == OP_XFER && !src_ok);
    assign exec   = cmd_valid && rdy;
    assign wr_en  = exec && !reject && (cmd_op != OP_NOP);

    always_comb begin
        result = '0;
        wrap_c = 1'b0;
        case (cmd_op)
            OP_LDSB: result = sb_in;
            OP_LDDB: result = db_in;
            OP_INC: begin
                result = dst_val + WIDTH'(1);
                wrap_c = &dst_val;
            end
            OP_DEC: begin
                result = dst_val - WIDTH'(1);
                wrap_c = ~|dst_val;
            end
            OP_XFER: result = src_val;
            OP_CLR:  result = '0;
            default: result = '0;
        endcase
    end

    // Writes to the stack pointer leave the flags alone (TXS behaviour).
    always_ff @(posedge ph0) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            flag_upd <= 1'b0;
            flag_z   <= 1'b1;
            flag_n   <= 1'b0;
            wrap     <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            flag_upd <= wr_en && !is_sp;
            wrap     <= wr_en && wrap_c;
            cmd_err  <= exec && reject;
            if (wr_en && !is_sp) begin
                flag_z <= (result == '0);
                flag_n <= result[WIDTH-1];
            end
            for (int i = 0; i < NREGS; i++)
                if (wr_en && cmd_dst == SELW'(i)) regs[i] <= result;
        end
    end

endmodule

// File: tb/tb_k6502_regfile.sv
// Bench for k6502_regfile: vector table and random model feed an expectation queue;
// hand sequences cover reset during a command and 16-bit wrap.
module tb_k6502_regfile;

    typedef struct {
        logic       rdy, vld;
        logic [2:0] op, dst, src;
        logic [7:0] sb, db;
        logic       ren;
        logic [2:0] rsel;
    } stim_t;

    typedef struct {
        logic [7:0] rd;
        logic       upd, z, n, wrap, err;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic       ph0 = 1'b0;
    logic       reset_n, rdy, cmd_valid, sb_ren, db_ren;
    logic [2:0] cmd_op, cmd_dst, cmd_src, sb_rsel, db_rsel;
    logic [7:0] sb_in, db_in, sb_out, db_out;
    logic       flag_upd, flag_z, flag_n, wrap, cmd_err;

    logic        w_reset_n, w_rdy, w_cmd_valid, w_sb_ren, w_db_ren;
    logic [2:0]  w_cmd_op;
    logic [1:0]  w_cmd_dst, w_cmd_src, w_sb_rsel, w_db_rsel;
    logic [15:0] w_sb_in, w_db_in, w_sb_out, w_db_out;
    logic        w_flag_upd, w_flag_z, w_flag_n, w_wrap, w_cmd_err;

    int passed = 0;
    int total  = 0;
    exp_t sbq[$];
    logic [7:0] m [4];
    logic mz, mn;
    vec_t vt [30];

    always #5 ph0 = ~ph0;

    k6502_regfile #(.SELW(3)) u_dut (
        .ph0(ph0), .reset_n(reset_n), .rdy(rdy), .cmd_valid(cmd_valid),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src),
        .sb_in(sb_in), .db_in(db_in), .sb_ren(sb_ren), .db_ren(db_ren),
        .sb_rsel(sb_rsel), .db_rsel(db_rsel), .sb_out(sb_out), .db_out(db_out),
        .flag_upd(flag_upd), .flag_z(flag_z), .flag_n(flag_n),
        .wrap(wrap), .cmd_err(cmd_err)
    );

    k6502_regfile #(.WIDTH(16), .SP_RESET(16'h01FD)) u_dut16 (
        .ph0(ph0), .reset_n(w_reset_n), .rdy(w_rdy), .cmd_valid(w_cmd_valid),
        .cmd_op(w_cmd_op), .cmd_dst(w_cmd_dst), .cmd_src(w_cmd_src),
        .sb_in(w_sb_in), .db_in(w_db_in), .sb_ren(w_sb_ren), .db_ren(w_db_ren),
        .sb_rsel(w_sb_rsel), .db_rsel(w_db_rsel), .sb_out(w_sb_out), .db_out(w_db_out),
        .flag_upd(w_flag_upd), .flag_z(w_flag_z), .flag_n(w_flag_n),
        .wrap(w_wrap), .cmd_err(w_cmd_err)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic r, v, input logic [2:0] op, dst, src,
                                input logic [7:0] sbv, dbv, input logic ren,
                                input logic [2:0] rsel, input logic [7:0] rd,
                                input logic upd, z, n, w, e);
        vec_t x;
        x.s = '{r, v, op, dst, src, sbv, dbv, ren, rsel};
        x.e = '{rd, upd, z, n, w, e};
        return x;
    endfunction

    task automatic check_out();
        exp_t e;
        if (sbq.size() == 0) begin
            total++;
            $display("FAIL scoreboard: no expectation queued at t=%0t", $time);
        end else begin
            e = sbq.pop_front();
            chk("sb_out", sb_out, e.rd);
            chk("db_out", db_out, e.rd);
            chk("flag_upd", flag_upd, e.upd);
            chk("flag_z", flag_z, e.z);
            chk("flag_n", flag_n, e.n);
            chk("wrap", wrap, e.wrap);
            chk("cmd_err", cmd_err, e.err);
        end
    endtask

    task automatic apply(input stim_t s, input exp_t e);
        @(negedge ph0);
        rdy = s.rdy; cmd_valid = s.vld; cmd_op = s.op; cmd_dst = s.dst; cmd_src = s.src;
        sb_in = s.sb; db_in = s.db; sb_ren = s.ren; db_ren = s.ren;
        sb_rsel = s.rsel; db_rsel = s.rsel;
        sbq.push_back(e);
        @(posedge ph0);
        #1 check_out();
    endtask

    // Reference behaviour of the default bank (A/X/Y/S, S exempt from flags).
    task automatic model_step(input stim_t s, output exp_t e);
        logic [7:0] old, r;
        e = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        if (s.rdy && s.vld) begin
            if (s.op == 3'd7 || s.dst >= 3'd4 || (s.op == 3'd5 && s.src >= 3'd4)) begin
                e.err = 1'b1;
            end else if (s.op != 3'd0) begin
                old = m[s.dst[1:0]];
                r = 8'h00;
                case (s.op)
                    3'd1: r = s.sb;
                    3'd2: r = s.db;
                    3'd3: begin r = old + 8'd1; e.wrap = (old == 8'hFF); end
                    3'd4: begin r = old - 8'd1; e.wrap = (old == 8'h00); end
                    3'd5: r = m[s.src[1:0]];
                    default: r = 8'h00;
                endcase
                m[s.dst[1:0]] = r;
                if (s.dst != 3'd3) begin
                    e.upd = 1'b1;
                    mz = (r == 8'h00);
                    mn = r[7];
                end
            end
        end
        e.z = mz;
        e.n = mn;
        e.rd = (s.ren && s.rsel < 3'd4) ? m[s.rsel[1:0]] : 8'h00;
    endtask

    task automatic w_step(input logic [2:0] op, input logic [1:0] dst, input logic [15:0] v,
                          input logic [1:0] rsel, input logic [15:0] rd,
                          input logic upd, z, n, w);
        @(negedge ph0);
        w_cmd_valid = 1'b1; w_cmd_op = op; w_cmd_dst = dst; w_sb_in = v; w_db_rsel = rsel;
        @(posedge ph0);
        #1;
        chk("w16_db_out", w_db_out, rd);
        chk("w16_flag_upd", w_flag_upd, upd);
        chk("w16_flag_z", w_flag_z, z);
        chk("w16_flag_n", w_flag_n, n);
        chk("w16_wrap", w_wrap, w);
    endtask

    initial begin
        exp_t e;
        stim_t s;
        reset_n = 1'b0; rdy = 1'b0; cmd_valid = 1'b1; cmd_op = 3'd3; cmd_dst = 3'd0;
        cmd_src = 3'd0; sb_in = 8'h00; db_in = 8'h00; sb_ren = 1'b0; db_ren = 1'b0;
        sb_rsel = 3'd3; db_rsel = 3'd3;
        w_reset_n = 1'b0; w_rdy = 1'b1; w_cmd_valid = 1'b0; w_cmd_op = 3'd0; w_cmd_dst = 2'd0;
        w_cmd_src = 2'd0; w_sb_in = 16'h0; w_db_in = 16'h0; w_sb_ren = 1'b0; w_db_ren = 1'b1;
        w_sb_rsel = 2'd0; w_db_rsel = 2'd3;

        // Reset wins over rdy=0 and a pending INC; reads disabled give 0.
        @(posedge ph0);
        #1;
        chk("rst_sb_out_disabled", sb_out, 8'h00);
        chk("rst_flag_upd", flag_upd, 1'b0);
        chk("rst_flag_z", flag_z, 1'b1);
        chk("rst_flag_n", flag_n, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_cmd_err", cmd_err, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++)
            apply('{1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b1, 3'(i)},
                  '{(i == 3) ? 8'hFD : 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});

        //          rdy vld op  dst src sb     db     ren rsel | rd   upd z n w e
        vt[0]  = mk(1, 1, 3'd1, 3'd1, 3'd0, 8'h80, 8'h00, 1, 3'd1, 8'h80, 1, 0, 1, 0, 0);
        vt[1]  = mk(1, 1, 3'd2, 3'd2, 3'd0, 8'h00, 8'hFF, 1, 3'd2, 8'hFF, 1, 0, 1, 0, 0);
        vt[2]  = mk(1, 1, 3'd3, 3'd2, 3'd0, 8'h00, 8'h00, 1, 3'd2, 8'h00, 1, 1, 0, 1, 0);
        vt[3]  = mk(1, 1, 3'd4, 3'd2, 3'd0, 8'h00, 8'h00, 1, 3'd2, 8'hFF, 1, 0, 1, 1, 0);
        vt[4]  = mk(1, 1, 3'd6, 3'd1, 3'd0, 8'h00, 8'h00, 1, 3'd1, 8'h00, 1, 1, 0, 0, 0);
        vt[5]  = mk(1, 1, 3'd1, 3'd0, 3'd0, 8'h90, 8'h00, 1, 3'd0, 8'h90, 1, 0, 1, 0, 0);
        vt[6]  = mk(1, 1, 3'd1, 3'd3, 3'd0, 8'h55, 8'h00, 1, 3'd3, 8'h55, 0, 0, 1, 0, 0);
        vt[7]  = mk(1, 1, 3'd5, 3'd3, 3'd1, 8'h00, 8'h00, 1, 3'd3, 8'h00, 0, 0, 1, 0, 0);
        vt[8]  = mk(1, 1, 3'd5, 3'd0, 3'd3, 8'h00, 8'h00, 1, 3'd0, 8'h00, 1, 1, 0, 0, 0);
        vt[9]  = mk(1, 1, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 1, 3'd0, 8'h00, 0, 1, 0, 0, 0);
        vt[10] = mk(1, 1, 3'd7, 3'd0, 3'd0, 8'h00, 8'h00, 1, 3'd0, 8'h00, 0, 1, 0, 0, 1);
        vt[11] = mk(1, 1, 3'd3, 3'd5, 3'd0, 8'h00, 8'h00, 1, 3'd5, 8'h00, 0, 1, 0, 0, 1);
        vt[12] = mk(1, 1, 3'd3, 3'd0, 3'd0, 8'h00, 8'h00, 1, 3'd0, 8'h01, 1, 0, 0, 0, 0);
        vt[13] = mk(1, 1, 3'd5, 3'd0, 3'd6, 8'h00, 8'h00, 1, 3'd0, 8'h01, 0, 0, 0, 0, 1);
        vt[14] = mk(1, 0, 3'd3, 3'd0, 3'd0, 8'h00, 8'h00, 1, 3'd0, 8'h01, 0, 0, 0, 0, 0);
        vt[15] = mk(1, 1, 3'd3, 3'd1, 3'd0, 8'h00, 8'h00, 1, 3'd1, 8'h01, 1, 0, 0, 0, 0);
        vt[16] = mk(1, 1, 3'd3, 3'd1, 3'd0, 8'h00, 8'h00, 1, 3'd1, 8'h02, 1, 0, 0, 0, 0);
        vt[17] = mk(1, 1, 3'd4, 3'd0, 3'd0, 8'h00, 8'h00, 1, 3'd0, 8'h00, 1, 1, 0, 0, 0);
        vt[18] = mk(1, 1, 3'd4, 3'd0, 3'd0, 8'h00, 8'h00, 1, 3'd0, 8'hFF, 1, 0, 1, 1, 0);
        vt[19] = mk(1, 1, 3'd5, 3'd0, 3'd0, 8'h00, 8'h00, 1, 3'd0, 8'hFF, 1, 0, 1, 0, 0);
        vt[20] = mk(1, 0, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 0, 3'd0, 8'h00, 0, 0, 1, 0, 0);
        vt[21] = mk(0, 1, 3'd3, 3'd0, 3'd0, 8'h00, 8'h00, 1, 3'd0, 8'hFF, 0, 0, 1, 0, 0);
        vt[22] = mk(0, 1, 3'd3, 3'd0, 3'd0, 8'h00, 8'h00, 1, 3'd0, 8'hFF, 0, 0, 1, 0, 0);
        vt[23] = mk(0, 1, 3'd3, 3'd0, 3'd0, 8'h00, 8'h00, 1, 3'd0, 8'hFF, 0, 0, 1, 0, 0);
        vt[24] = mk(1, 1, 3'd3, 3'd0, 3'd0, 8'h00, 8'h00, 1, 3'd0, 8'h00, 1, 1, 0, 1, 0);
        vt[25] = mk(0, 1, 3'd7, 3'd0, 3'd0, 8'h00, 8'h00, 1, 3'd0, 8'h00, 0, 1, 0, 0, 0);
        vt[26] = mk(1, 1, 3'd2, 3'd2, 3'd0, 8'h00, 8'h7F, 1, 3'd2, 8'h7F, 1, 0, 0, 0, 0);
        vt[27] = mk(1, 1, 3'd3, 3'd3, 3'd0, 8'h00, 8'h00, 1, 3'd3, 8'h01, 0, 0, 0, 0, 0);
        vt[28] = mk(1, 1, 3'd6, 3'd4, 3'd0, 8'h00, 8'h00, 1, 3'd4, 8'h00, 0, 0, 0, 0, 1);
        vt[29] = mk(1, 1, 3'd5, 3'd1, 3'd4, 8'h00, 8'h00, 1, 3'd1, 8'h02, 0, 0, 0, 0, 1);
        foreach (vt[i]) apply(vt[i].s, vt[i].e);

        // Reset while a command and a stall are present: command dropped, S back to FD.
        @(negedge ph0);
        reset_n = 1'b0; rdy = 1'b0; cmd_valid = 1'b1; cmd_op = 3'd1; cmd_dst = 3'd3;
        sb_in = 8'hAA; sb_ren = 1'b1; db_ren = 1'b1; sb_rsel = 3'd3; db_rsel = 3'd3;
        @(posedge ph0);
        #1;
        chk("rstcmd_s", sb_out, 8'hFD);
        chk("rstcmd_flag_upd", flag_upd, 1'b0);
        chk("rstcmd_flag_z", flag_z, 1'b1);
        chk("rstcmd_cmd_err", cmd_err, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++)
            apply('{1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b1, 3'(i)},
                  '{(i == 3) ? 8'hFD : 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});

        // Random traffic against the model, starting from the reset state.
        m[0] = 8'h00; m[1] = 8'h00; m[2] = 8'h00; m[3] = 8'hFD;
        mz = 1'b1; mn = 1'b0;
        for (int k = 0; k < 400; k++) begin
            s.rdy  = ($urandom_range(0, 5) != 0);
            s.vld  = ($urandom_range(0, 4) != 0);
            s.op   = 3'($urandom_range(0, 7));
            s.dst  = 3'($urandom_range(0, 4));
            s.src  = 3'($urandom_range(0, 4));
            s.sb   = 8'($urandom);
            s.db   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            s.ren  = ($urandom_range(0, 3) != 0);
            s.rsel = 3'($urandom_range(0, 5));
            model_step(s, e);
            apply(s, e);
        end

        // 16-bit bank: SP reset value and wrap at 16'hFFFF.
        chk("w16_rst_s", w_db_out, 16'h01FD);
        chk("w16_rst_flag_z", w_flag_z, 1'b1);
        w_reset_n = 1'b1;
        w_step(3'd1, 2'd0, 16'hFFFF, 2'd0, 16'hFFFF, 1, 0, 1, 0);
        w_step(3'd3, 2'd0, 16'h0000, 2'd0, 16'h0000, 1, 1, 0, 1);
        w_step(3'd4, 2'd0, 16'h0000, 2'd0, 16'hFFFF, 1, 0, 1, 1);
        w_step(3'd1, 2'd1, 16'h00FF, 2'd1, 16'h00FF, 1, 0, 0, 0);
        w_step(3'd3, 2'd1, 16'h0000, 2'd1, 16'h0100, 1, 0, 0, 0);
        w_step(3'd4, 2'd3, 16'h0000, 2'd3, 16'h01FC, 0, 0, 0, 0);

        chk("scoreboard_drained", 16'(sbq.size()), 16'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/k6502_regfile.md
# k6502_regfile

Parametrised programmer-visible register bank for the k6502 core, generalising the fixed A/X/Y index and accumulator registers into one block with NREGS registers of WIDTH bits. Registers load from the SB or DB internal bus, increment and decrement in place, and transfer register-to-register. The bank drives either bus from any register and produces registered Z/N flag updates. It sits between the internal buses and the status-register logic and honours the RDY stall line.

## Interface
Parameters:
- WIDTH, 8, register and bus width in bits.
- NREGS, 4, number of registers. Index 0=A, 1=X, 2=Y, 3=S in the default configuration.
- SP_IDX, 3, index of the stack-pointer register. Set to NREGS or greater to disable the stack-pointer special case.
- SP_RESET, 8'hFD, reset value of register SP_IDX, truncated or zero-extended to WIDTH.
- SELW, $clog2(NREGS) (minimum 1), width of the register-select fields.

Ports:
- ph0  in  1  clock. All state changes on the rising edge.
- reset_n  in  1  reset. Synchronous, active-low. One clock; reset is synchronous and active-low.
- rdy  in  1  1=run. 0=stall: commands ignored, all state held.
- cmd_valid  in  1  command present this cycle.
- cmd_op  in  3  0 NOP, 1 LD_SB, 2 LD_DB, 3 INC, 4 DEC, 5 XFER, 6 CLR, 7 reserved.
- cmd_dst  in  SELW  destination register.
- cmd_src  in  SELW  source register (XFER only).
- sb_in  in  WIDTH  SB bus value for LD_SB.
- db_in  in  WIDTH  DB bus value for LD_DB.
- sb_ren, db_ren  in  1  enable register drive onto SB and DB respectively.
- sb_rsel, db_rsel  in  SELW  register driven onto each bus.
- sb_out, db_out  out  WIDTH  selected register value. 0 when the enable is low or the select is out of range.
- flag_upd  out  1  registered pulse: flag_z and flag_n are valid this cycle.
- flag_z, flag_n  out  1  zero and sign (bit WIDTH-1) of the last flag-updating write.
- wrap  out  1  registered pulse: the last INC or DEC wrapped.
- cmd_err  out  1  registered pulse: the last command was rejected.

## Operation
- A command executes when cmd_valid=1 and rdy=1 at a rising edge. One write per cycle at most.
- LD_SB: reg[dst] <= sb_in.
- LD_DB: reg[dst] <= db_in.
- INC: reg[dst] <= reg[dst]+1, modulo 2^WIDTH. wrap=1 when the old value was all-ones.
- DEC: reg[dst] <= reg[dst]-1, modulo 2^WIDTH. wrap=1 when the old value was 0.
- XFER: reg[dst] <= reg[src]. When src==dst the value is unchanged but flags still update.
- CLR: reg[dst] <= 0.
- NOP: no state change. No flag_upd, no cmd_err.
- Flags: every executed LD/INC/DEC/XFER/CLR asserts flag_upd the next cycle, with Z=(result==0) and N=result[WIDTH-1].
  - Exception: a write to dst==SP_IDX (any op) updates the register but asserts no flag_upd and leaves flag_z and flag_n unchanged (TXS semantics).
- Rejection: op=7, dst>=NREGS, or XFER with src>=NREGS. The command does not modify any register, produces no flag_upd, and pulses cmd_err the next cycle.
- Reads are combinational from current register contents. There is no write-to-read bypass: a same-cycle read of the register being written returns the old value.
- sb and db may select the same register simultaneously. Both outputs carry the same value.
- Stall: while rdy=0, registers, flag_z and flag_n hold. flag_upd, wrap and cmd_err are 0. Reads continue to operate.

## Timing
- Reset (reset_n=0 at an edge): all registers 0 except reg[SP_IDX]=SP_RESET.
  - flag_z=1, flag_n=0, flag_upd=0, wrap=0, cmd_err=0.
  - Reset has priority over a simultaneous command and over rdy=0.
- Reset during a command: the command is discarded and no pulses are issued afterwards.
- Write latency: 1 cycle. A value written at edge k is visible on sb_out and db_out after edge k.
- Pulse latency: flag_upd, wrap and cmd_err assert exactly one cycle after the command edge, for exactly one cycle.
- Back-to-back commands on consecutive cycles are supported. Each INC uses the value left by the previous edge, so two INCs give +2.
- Pulse outputs are low during any cycle that follows a stalled cycle or an invalid-free NOP.

## Test plan
- Reset with default parameters: A=X=Y=0, S=8'hFD. flag_z=1, flag_n=0, all pulses 0, sb_out=0 with sb_ren=0.
- LD_SB dst=1 sb_in=8'h80, then read X on db: db_out=8'h80. Next cycle flag_upd=1, flag_n=1, flag_z=0.
- LD_DB dst=2 db_in=8'hFF, then INC dst=2: Y=8'h00, wrap=1, flag_z=1. Then DEC dst=2: Y=8'hFF, wrap=1, flag_n=1.
- XFER src=1 dst=3 with X=8'h00: S=8'h00, no flag_upd, flags unchanged. Then XFER src=3 dst=0: A=8'h00, flag_upd=1, flag_z=1.
- rdy=0 for 3 cycles with INC dst=0 asserted: A unchanged, no pulses. When rdy returns to 1, one INC applies: A=8'h01.
- cmd_op=7, then INC dst=5 with NREGS=4: each pulses cmd_err=1 one cycle later. All registers unchanged, flag_upd=0. Repeat with WIDTH=16, SP_RESET=16'h01FD to check wrap at 16'hFFFF.
